// File: rtl/ucore_pkg.sv
// ucore_pkg: shared constants for the ucore slice.
//   UCORE_DATA_W    - width of one ucore result word
//   UCORE_OUT_DEPTH - default entry count of the ucore output buffer
package ucore_pkg;

  localparam int unsigned UCORE_DATA_W    = 32;
  localparam int unsigned UCORE_OUT_DEPTH = 4;

endpackage : ucore_pkg

// File: rtl/ucore_fifo_mem.sv
// ucore_fifo_mem: DEPTH x DATA_W register array for the ucore output buffer.
// Contents are not reset; only the surrounding pointers are.
// Ports:
//   clk   - clock, writes take effect on the rising edge
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - asynchronous read address
//   rdata - asynchronous read data (mem[raddr])
module ucore_fifo_mem #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : ucore_fifo_mem

// File: rtl/ucore_out_fifo.sv
// ucore_out_fifo: first-word-fall-through output buffer behind ucore_main.
// Accepts result words on the core valid/enable handshake and presents them
// to the sink over ready/valid. The core stalls only while the buffer is full.
// Ports:
//   clk         - single clock, rising edge
//   aresetn     - synchronous active-low reset (pointers and count only)
//   core_valid  - ucore_main offers core_data
//   core_data   - result word from ucore_main
//   core_enable - buffer not full; drives the enable input of ucore_main
//   out_valid   - head word present on out_data
//   out_data    - head word, 0 while empty
//   out_ready   - sink takes the head word this cycle
// Optional (macro UCORE_OUT_FIFO_LEVEL_EN):
//   level         - registered occupancy
//   overflow_seen - sticky flag, core offered a word while not enabled
module ucore_out_fifo
  import ucore_pkg::*;
#(
  parameter  int unsigned DATA_W = UCORE_DATA_W,
  parameter  int unsigned DEPTH  = UCORE_OUT_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              core_valid,
  input  logic [DATA_W-1:0] core_data,
  output logic              core_enable,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
`ifdef UCORE_OUT_FIFO_LEVEL_EN
  ,
  output logic [ADDR_W:0]   level,
  output logic              overflow_seen
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] rdata;

  // Both flags decode the registered count only, so out_ready never
  // reaches core_enable combinationally: a pop at full frees space one
  // cycle later.
  assign core_enable = (count != FULL_CNT);
  assign out_valid   = (count != '0);

  assign push = core_valid && core_enable;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  ucore_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (core_data),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Storage is not reset, so the head is masked while empty.
  assign out_data = out_valid ? rdata : '0;

`ifdef UCORE_OUT_FIFO_LEVEL_EN
  assign level = count;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      overflow_seen <= 1'b0;
    end else if (core_valid && !core_enable) begin
      overflow_seen <= 1'b1;
    end
  end
`endif

endmodule : ucore_out_fifo

// File: tb/tb_ucore_out_fifo.sv
// tb_ucore_out_fifo: scoreboard bench for ucore_out_fifo with a queue model.
// The driver predicts acceptance from the model occupancy and queues the
// expected words; the monitor checks flags and pops/compares on each transfer.
module tb_ucore_out_fifo;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              clk;
  logic              aresetn;
  logic              core_valid;
  logic [DATA_W-1:0] core_data;
  logic              core_enable;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
`ifdef UCORE_OUT_FIFO_LEVEL_EN
  logic [ADDR_W:0]   level;
  logic              overflow_seen;
`endif

  ucore_out_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .core_valid  (core_valid),
    .core_data   (core_data),
    .core_enable (core_enable),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready)
`ifdef UCORE_OUT_FIFO_LEVEL_EN
    ,
    .level         (level),
    .overflow_seen (overflow_seen)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [DATA_W-1:0] exp_q[$];
  int unsigned       mcnt;
  logic              exp_ovf;
  logic              chk_en;

  int unsigned n_chk;
  int unsigned n_pass;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
  endtask

  // Monitor: DUT outputs settle long before the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", DATA_W'(out_valid), DATA_W'(mcnt != 0));
      check("core_enable", DATA_W'(core_enable), DATA_W'(mcnt != DEPTH));
      if (!out_valid) check("out_data_idle", out_data, '0);
`ifdef UCORE_OUT_FIFO_LEVEL_EN
      check("level", DATA_W'(level), DATA_W'(mcnt));
      check("overflow_seen", DATA_W'(overflow_seen), DATA_W'(exp_ovf));
`endif
      if (aresetn && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL pop_empty at %0t: got 0x%0h expected no word", $time, out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  // One cycle: inputs applied just after a rising edge, model advanced just
  // after the falling edge (after the monitor has sampled).
  task automatic step(input logic cv, input logic [DATA_W-1:0] d,
                      input logic rdy, output logic acc);
    logic pop_ok;
    core_valid = cv;
    core_data  = d;
    out_ready  = rdy;
    @(negedge clk);
    #1;
    acc    = cv && (mcnt != DEPTH);
    pop_ok = rdy && (mcnt != 0);
    if (cv && mcnt == DEPTH) exp_ovf = 1'b1;
    if (acc) exp_q.push_back(d);
    mcnt = mcnt + (acc ? 1 : 0) - (pop_ok ? 1 : 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int unsigned edges);
    aresetn    = 1'b0;
    core_valid = 1'b0;
    out_ready  = 1'b0;
    for (int unsigned i = 0; i < edges; i++) begin
      @(negedge clk);
      #1;
      exp_q.delete();
      mcnt    = 0;
      exp_ovf = 1'b0;
      @(posedge clk);
      #1;
    end
    aresetn = 1'b1;
  endtask

  initial begin
    logic        acc;
    logic        cv;
    int unsigned guard;
    logic [DATA_W-1:0] w;

    n_chk = 0; n_pass = 0; mcnt = 0; exp_ovf = 1'b0; chk_en = 1'b0;
    aresetn = 1'b0; core_valid = 1'b0; core_data = '0; out_ready = 1'b0;

    // Reset then idle
    @(posedge clk); @(posedge clk); #1;
    aresetn = 1'b1;
    chk_en  = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 32'hFFFF_FFFF, 1'b0, acc);

    // Single transfer
    step(1'b1, 32'hDEAD_BEEF, 1'b1, acc);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, acc);

    // Fill to full, hold a fifth word, then drain
    for (int i = 1; i <= 4; i++) step(1'b1, DATA_W'(i), 1'b0, acc);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h5, 1'b0, acc);
    acc = 1'b0; guard = 0;
    while (!acc && guard < 10) begin
      step(1'b1, 32'h5, 1'b1, acc);
      guard++;
    end
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, acc);

    // Streaming through a steady occupancy of one
    for (int i = 0; i < 20; i++) step(1'b1, DATA_W'(i), 1'b1, acc);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, acc);

    // Reset with three buffered words
    for (int i = 0; i < 3; i++) step(1'b1, 32'hA000 + DATA_W'(i), 1'b0, acc);
    do_reset(1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, acc);

    // Random traffic, respecting the model's free space
    w = $urandom;
    for (int i = 0; i < 500; i++) begin
      cv = ($urandom_range(9) < 7) && (mcnt != DEPTH);
      step(cv, w, $urandom_range(1) == 1, acc);
      if (acc) w = $urandom;
    end
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, acc);

    check("final_queue_empty", DATA_W'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_ucore_out_fifo
